// File: rtl/bj_pkg.sv
// Shared definitions for the blackjack dealer block.
// Holds card/slot geometry, the FSM state type, the LFSR feedback tap mask
// and a small helper that tells whether a drawn card code is playable.
package bj_pkg;

  localparam int CARD_W     = 4;
  localparam int SLOT_COUNT = 4;
  // Card codes at or above this value mark an empty slot and are never dealt.
  localparam int CARD_LIMIT = 13;

  // Feedback taps for x^8+x^6+x^5+x^4+1 on a left-shifting register:
  // bits 7, 5, 4 and 3 are XORed to form the new bit 0.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_DRAW,
    S_LOAD,
    S_SETTLE,
    S_DONE
  } state_t;

  function automatic logic card_valid(input logic [CARD_W-1:0] code);
    return code < CARD_W'(CARD_LIMIT);
  endfunction

endpackage

// File: rtl/bj_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used as the dealer's card source.
// Ports:
//   clk  - system clock, rising edge
//   clr  - synchronous active-high reset, loads SEED
//   card - low nibble of the register, the candidate card code
module bj_lfsr
  import bj_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic                clk,
  input  logic                clr,
  output logic [CARD_W-1:0]   card
);

  logic [7:0] lfsr;
  logic       feedback;

  assign feedback = ^(lfsr & LFSR_TAPS);
  assign card     = lfsr[CARD_W-1:0];

  // Shifts on every non-reset edge; SEED must be nonzero or it locks up.
  always_ff @(posedge clk) begin
    if (clr) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[6:0], feedback};
    end
  end

endmodule

// File: rtl/bj_dealer.sv
// Dealer for the 4-slot blackjack hand register.
// Deals INIT_CARDS cards on START and one more per HIT, writing each card
// through the register's LD/POS/D interface, and watches the returned hand
// total to flag a bust. Dealing stops on bust or when all slots are full.
// Ports:
//   CLK        - system clock, rising edge
//   CLR        - synchronous active-high reset
//   START      - begin a new round (honoured in IDLE and DONE)
//   HIT        - request one more card (honoured in IDLE with 1..3 cards)
//   FORCE_EN   - take cards from FORCE_CARD instead of the LFSR
//   FORCE_CARD - forced card code
//   CNT        - hand total returned by the hand register
//   LD/POS/D   - registered load strobe, slot index and card code
//   HAND_CLR   - registered one-cycle clear of the hand register
//   BUSY       - a deal sequence is in progress
//   BUST/FULL  - latched round outcome flags
//   NCARDS     - cards dealt this round
module bj_dealer
  import bj_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED  = 8'hA5,
  parameter int         BUST_LIMIT = 21,
  parameter int         INIT_CARDS = 2
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              START,
  input  logic              HIT,
  input  logic              FORCE_EN,
  input  logic [CARD_W-1:0] FORCE_CARD,
  input  logic [5:0]        CNT,
  output logic              LD,
  output logic [1:0]        POS,
  output logic [CARD_W-1:0] D,
  output logic              HAND_CLR,
  output logic              BUSY,
  output logic              BUST,
  output logic              FULL,
  output logic [2:0]        NCARDS
);

  localparam logic [5:0] BUST_LIM6  = 6'(BUST_LIMIT);
  localparam logic [2:0] INIT_N     = 3'(INIT_CARDS);
  localparam logic [2:0] SLOTS_N    = 3'(SLOT_COUNT);

  state_t            state;
  state_t            next_state;
  logic [2:0]        pending;
  logic [2:0]        ncards;
  logic [CARD_W-1:0] lfsr_card;
  logic [CARD_W-1:0] candidate;
  logic              over_limit;

  bj_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk  (CLK),
    .clr  (CLR),
    .card (lfsr_card)
  );

  assign candidate  = FORCE_EN ? FORCE_CARD : lfsr_card;
  assign over_limit = CNT > BUST_LIM6;

  assign NCARDS = ncards;
  assign BUSY   = (state == S_CLEAR) || (state == S_DRAW) ||
                  (state == S_LOAD)  || (state == S_SETTLE);

  // Next-state logic. START takes priority over HIT in IDLE; in SETTLE the
  // bust test comes before the full test so a busting fourth card reports
  // BUST rather than FULL.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (START) begin
          next_state = S_CLEAR;
        end else if (HIT && (ncards != 3'd0) && (ncards < SLOTS_N)) begin
          next_state = S_DRAW;
        end
      end
      S_CLEAR: next_state = S_DRAW;
      S_DRAW: begin
        if (card_valid(candidate)) begin
          next_state = S_LOAD;
        end
      end
      S_LOAD: next_state = S_SETTLE;
      S_SETTLE: begin
        if (over_limit) begin
          next_state = S_DONE;
        end else if (ncards == SLOTS_N) begin
          next_state = S_DONE;
        end else if (pending != 3'd0) begin
          next_state = S_DRAW;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_DONE: begin
        if (START) begin
          next_state = S_CLEAR;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // State, counters and registered outputs. LD and HAND_CLR are flopped from
  // the next state so they are high exactly while LOAD / CLEAR is current,
  // which keeps input changes from reaching the hand register directly.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state    <= S_IDLE;
      pending  <= 3'd0;
      ncards   <= 3'd0;
      LD       <= 1'b0;
      POS      <= 2'd0;
      D        <= '0;
      HAND_CLR <= 1'b0;
      BUST     <= 1'b0;
      FULL     <= 1'b0;
    end else begin
      state    <= next_state;
      LD       <= (next_state == S_LOAD);
      HAND_CLR <= (next_state == S_CLEAR);
      case (state)
        S_IDLE: begin
          if (next_state == S_CLEAR) begin
            pending <= INIT_N;
          end else if (next_state == S_DRAW) begin
            pending <= 3'd1;
          end
        end
        S_CLEAR: begin
          ncards <= 3'd0;
          BUST   <= 1'b0;
          FULL   <= 1'b0;
        end
        S_DRAW: begin
          if (next_state == S_LOAD) begin
            D   <= candidate;
            POS <= ncards[1:0];
          end
        end
        S_LOAD: begin
          ncards  <= ncards + 3'd1;
          pending <= pending - 3'd1;
        end
        S_SETTLE: begin
          if (over_limit) begin
            BUST <= 1'b1;
          end else if (ncards == SLOTS_N) begin
            FULL <= 1'b1;
          end
        end
        S_DONE: begin
          if (next_state == S_CLEAR) begin
            pending <= INIT_N;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/bj_dealer.md
Name: bj_dealer

Overview:
Dealer/writer for the 4-slot blackjack hand register. Drives that register's LD/POS/D load interface and its clear. Reads back the register's 6-bit hand total CNT to detect bust.
- Deals two opening cards on START, then one card per HIT.
- Stops dealing on bust or when all 4 slots are full.
- Cards come from a free-running LFSR, or from a forced value for test.

Parameters:
LFSR_SEED, 8'hA5, reset value of the 8-bit card LFSR (must be nonzero)
BUST_LIMIT, 21, hand total above which BUST asserts
INIT_CARDS, 2, cards dealt per START (1..4)

Ports:
CLK  in  1  system clock, rising edge
CLR  in  1  synchronous active-high reset
START  in  1  begin new round (1-cycle pulse or level; sampled in IDLE/DONE)
HIT  in  1  request one more card (sampled in IDLE only)
FORCE_EN  in  1  1 = use FORCE_CARD instead of LFSR in DRAW
FORCE_CARD  in  4  forced card code
CNT  in  6  hand total fed back from the hand register
LD  out  1  load strobe to hand register
POS  out  2  slot index for load
D  out  4  card code for load (0..12; 0 and 10..12 count 10, 1..9 face value)
HAND_CLR  out  1  1-cycle clear to hand register (sets all slots empty)
BUSY  out  1  dealing in progress
BUST  out  1  latched: CNT > BUST_LIMIT after a load
FULL  out  1  latched: 4 cards dealt
NCARDS  out  3  cards dealt this round (0..4)

Behaviour:
- Reset (CLR=1 at edge): state IDLE; LD=0, POS=0, D=0, HAND_CLR=0, BUSY=0, BUST=0, FULL=0, NCARDS=0; LFSR=LFSR_SEED; pending=0. CLR overrides all other inputs.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Shifts every cycle, including during reset release. Candidate card = lfsr[3:0].
- Outputs: LD/POS/D/HAND_CLR are registered. They decode from state and registers only, with no combinational path from inputs.
- States: IDLE, CLEAR, DRAW, LOAD, SETTLE, DONE.
- IDLE, START=1 -> CLEAR; pending=INIT_CARDS. START wins over a simultaneous HIT.
- IDLE, HIT=1, NCARDS in 1..3 -> DRAW; pending=1. HIT with NCARDS=0 is ignored.
- CLEAR: HAND_CLR=1 for exactly one cycle; NCARDS, BUST, FULL cleared -> DRAW.
- DRAW: candidate = FORCE_EN ? FORCE_CARD : lfsr[3:0].
  - Candidate >=13: reject, stay in DRAW (1 cycle per retry, no LD).
  - Candidate <13: latch into D -> LOAD.
- LOAD: LD=1 one cycle, POS=NCARDS[1:0]. NCARDS++, pending-- -> SETTLE.
- SETTLE: one cycle. CNT reflects the new card here, since the register updates on the LOAD edge and CNT is combinational.
  - CNT > BUST_LIMIT: BUST=1 -> DONE.
  - Else NCARDS==4: FULL=1 -> DONE.
  - Else pending>0 -> DRAW.
  - Else -> IDLE.
- DONE: HIT ignored; START -> CLEAR (new round).
- BUSY=1 in CLEAR/DRAW/LOAD/SETTLE; 0 in IDLE/DONE.
- START or HIT while BUSY is ignored (no queueing).
- Latency, forced valid cards, START sampled at edge t: HAND_CLR at t+1, LD POS0 at t+3, LD POS1 at t+6, BUSY low from t+8. HIT adds 3 cycles (DRAW, LOAD, SETTLE).
- Arithmetic: BUST compare is unsigned 6-bit. BUST_LIMIT is zero-extended to 6 bits. NCARDS saturates at 4 by construction.
- CLR mid-round: next edge returns to IDLE with LD=0. The top level ORs CLR into the hand register's clear, so no partial load survives.

Decomposition:
- Package bj_pkg: card width constant (4), slot count (4), empty-slot code threshold (13), state enum typedef, LFSR tap mask constant.
- Sub-module bj_lfsr: 8-bit free-running LFSR with seed parameter. Instantiated once.
- FSM, counters and output regs stay in bj_dealer.

Test Plan:
- FORCE_EN=1, FORCE_CARD=9, START pulse at t with hand register model attached -> HAND_CLR at t+1; LD POS0 D=9 at t+3; LD POS1 D=9 at t+6; CNT=18, NCARDS=2, BUSY=0 at t+8; BUST=0.
- Continue with FORCE_CARD=5, HIT -> LD POS2 D=5; CNT=23; BUST=1; DONE. Further HIT produces no LD; START restarts (HAND_CLR, NCARDS=0, BUST=0).
- START with FORCE_CARD=14 held 3 cycles in DRAW, then 3 -> no LD during the 3 cycles, then LD POS0 D=3. Retries cost exactly 1 cycle each.
- Forced cards 2,3 then HITs with 4,5 -> CNT=14, NCARDS=4, FULL=1, BUST=0. Fifth HIT ignored.
- CLR asserted during SETTLE of second card -> next cycle state IDLE; all outputs at reset values; LFSR=8'hA5.
- FORCE_EN=0 after reset, START -> D values match the software LFSR model (seed A5, taps 8/6/5/4), with codes >=13 skipped. Same START and HIT timing gives the same sequence every run.
